serving_timer: RTL and testbench

- Wishbone-slave machine timer sitting downstream of the serving SoC external bus (o_wb_* / i_wb_*).
- Its o_irq output feeds back into the SoC i_timer_irq input.
- Provides a free-running 64-bit mtime counter and a 64-bit mtimecmp compare register.
- Raises a level interrupt while mtime >= mtimecmp, matching RISC-V machine-timer semantics.

---
 rtl/serving_timer_if.sv | 14 +
 rtl/serving_timer.sv | 112 +++++++++++
 tb/tb_serving_timer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/serving_timer_if.sv
// Wishbone classic bus bundle between the serving SoC external port and the timer.
// Carries request (adr/dat/sel/we/stb) and response (rdt/ack) signals.
interface serving_timer_if;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        stb;
    logic [31:0] rdt;
    logic        ack;

    modport master (output adr, dat, sel, we, stb, input  rdt, ack);
    modport slave  (input  adr, dat, sel, we, stb, output rdt, ack);
endinterface

// File: rtl/serving_timer.sv
// RISC-V style machine timer (64-bit mtime/mtimecmp) behind a Wishbone slave port.
// Optional mtime prescaler enabled by defining SERVING_TIMER_PRESCALE_EN.
module serving_timer #(
    parameter logic [63:0] RESET_CMP = 64'hFFFF_FFFF_FFFF_FFFF,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    serving_timer_if.slave wb,
    output logic           o_irq
);
    localparam logic [1:0] A_MTIME_LO = 2'd0;
    localparam logic [1:0] A_MTIME_HI = 2'd1;
    localparam logic [1:0] A_CMP_LO   = 2'd2;

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] cmp_q, cmp_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] rdt_q, rdt_d;
    logic        ack_q, irq_q;
    logic        tick, access, wr;
    logic [1:0]  reg_sel;
    logic [32:0] lo_inc;
    logic        unused;

    function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] wdat,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = cur;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = wdat[8*b +: 8];
        return r;
    endfunction

    // The cycle after an ack is never a new access, so held stb cannot double-apply.
    assign access  = wb.stb & ~ack_q;
    assign wr      = access & wb.we;
    assign reg_sel = wb.adr[3:2];
    assign unused  = ^{wb.adr[31:4], wb.adr[1:0]};

`ifdef SERVING_TIMER_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
    logic [PW-1:0] ps_q, ps_d;

    always_comb begin
        tick = (ps_q == PS_LAST);
        ps_d = tick ? '0 : ps_q + PW'(1);
        // Software setting mtime restarts the tick phase.
        if (wr && !reg_sel[1]) ps_d = '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) ps_q <= '0;
        else          ps_q <= ps_d;
    end
`else
    logic unused_ps;
    assign unused_ps = 1'(PRESCALE);
    assign tick      = 1'b1;
`endif

    assign lo_inc = {1'b0, mtime_q[31:0]} + 33'(tick);

    always_comb begin
        mtime_d  = {mtime_q[63:32] + {31'd0, lo_inc[32]}, lo_inc[31:0]};
        cmp_d    = cmp_q;
        shadow_d = shadow_q;
        rdt_d    = '0;
        if (wr) begin
            case (reg_sel)
                // LO write freezes the whole counter for this cycle.
                A_MTIME_LO: mtime_d        = {mtime_q[63:32], merge(mtime_q[31:0], wb.dat, wb.sel)};
                A_MTIME_HI: mtime_d[63:32] = merge(mtime_q[63:32], wb.dat, wb.sel);
                A_CMP_LO:   cmp_d[31:0]    = merge(cmp_q[31:0], wb.dat, wb.sel);
                default:    cmp_d[63:32]   = merge(cmp_q[63:32], wb.dat, wb.sel);
            endcase
        end else if (access) begin
            case (reg_sel)
                A_MTIME_LO: begin
                    rdt_d    = mtime_q[31:0];
                    shadow_d = mtime_q[63:32];
                end
                A_MTIME_HI: rdt_d = shadow_q;
                A_CMP_LO:   rdt_d = cmp_q[31:0];
                default:    rdt_d = cmp_q[63:32];
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mtime_q  <= '0;
            cmp_q    <= RESET_CMP;
            shadow_q <= '0;
            rdt_q    <= '0;
            ack_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            mtime_q  <= mtime_d;
            cmp_q    <= cmp_d;
            shadow_q <= shadow_d;
            rdt_q    <= rdt_d;
            ack_q    <= access;
            irq_q    <= (mtime_q >= cmp_q);
        end
    end

    assign wb.rdt = rdt_q;
    assign wb.ack = ack_q;
    assign o_irq  = irq_q;
endmodule

// File: tb/tb_serving_timer.sv
// Directed self-checking bench for serving_timer; expected values are hand-derived
// from the cycle position of each Wishbone access (access edge = first rising edge after stb).
module tb_serving_timer;
`ifdef SERVING_TIMER_PRESCALE_EN
    localparam int unsigned TB_PS = 4;
`else
    localparam int unsigned TB_PS = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        irq;
    logic [31:0] r;
    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc    = 0;

    serving_timer_if wb();

    serving_timer #(.RESET_CMP(64'hFFFF_FFFF_FFFF_FFFF), .PRESCALE(TB_PS)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .wb(wb), .o_irq(irq)
    );

    always #5 clk = ~clk;

    // Rising edges since reset release; equals mtime while software has not written it.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called and returns at a falling edge; hold keeps stb up through the post-ack cycle.
    task automatic xfer(input logic [3:0] a, input logic we, input logic [31:0] d,
                        input logic [3:0] s, input bit hold, output logic [31:0] rd);
        int n;
        wb.adr = {28'd0, a};
        wb.dat = d;
        wb.sel = s;
        wb.we  = we;
        wb.stb = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wb.ack && n < 4);
        chk("ack_seen", 64'(wb.ack), 64'd1);
        rd = wb.rdt;
        if (hold) begin
            @(negedge clk);
            chk("ack_one_cycle", 64'(wb.ack), 64'd0);
            chk("rdt_hold_zero", 64'(wb.rdt), 64'd0);
        end
        wb.stb = 1'b0;
        wb.we  = 1'b0;
        @(negedge clk);
        chk("ack_idle", 64'(wb.ack), 64'd0);
        chk("rdt_idle", 64'(wb.rdt), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wb.adr = '0; wb.dat = '0; wb.sel = '0; wb.we = 1'b0; wb.stb = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ack", 64'(wb.ack), 64'd0);
        chk("rst_rdt", 64'(wb.rdt), 64'd0);
        chk("rst_irq", 64'(irq), 64'd0);
        rst_n = 1'b1;

`ifdef SERVING_TIMER_PRESCALE_EN
        repeat (40) @(negedge clk);
        xfer(4'h0, 1'b0, 32'd0, 4'h0, 1'b0, r);
        chk("ps_mtime40", 64'(r), 64'd10);
        xfer(4'h0, 1'b1, 32'd0, 4'hF, 1'b0, r);
        @(negedge clk);
        xfer(4'h0, 1'b0, 32'd0, 4'h0, 1'b0, r);
        chk("ps_restart_hold", 64'(r), 64'd0);
        xfer(4'h0, 1'b0, 32'd0, 4'h0, 1'b0, r);
        chk("ps_restart_tick", 64'(r), 64'd1);
`else
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_irq", 64'(irq), 64'd0);
        end
        xfer(4'h0, 1'b0, 32'd0, 4'h0, 1'b0, r);
        chk("idle_mtime", 64'(r), 64'd10);

        // irq level tracks mtime >= 0x40 with one cycle latency
        xfer(4'hC, 1'b1, 32'd0, 4'hF, 1'b0, r);
        xfer(4'h8, 1'b1, 32'h40, 4'hF, 1'b0, r);
        while (cyc < 72) begin
            @(negedge clk);
            chk("irq_level", 64'(irq), 64'((cyc - 1) >= 64));
        end
        xfer(4'h8, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b0, r);
        chk("irq_fall", 64'(irq), 64'd0);

        // tear-free 64-bit read across a low-word carry
        xfer(4'h4, 1'b1, 32'd0, 4'hF, 1'b0, r);
        xfer(4'h0, 1'b1, 32'hFFFF_FFFE, 4'hF, 1'b0, r);
        repeat (4) @(negedge clk);
        xfer(4'h0, 1'b0, 32'd0, 4'h0, 1'b0, r);
        chk("carry_lo", 64'(r), 64'd3);
        xfer(4'h4, 1'b0, 32'd0, 4'h0, 1'b0, r);
        chk("carry_hi", 64'(r), 64'd1);
        xfer(4'h4, 1'b1, 32'd7, 4'hF, 1'b0, r);
        xfer(4'h4, 1'b0, 32'd0, 4'h0, 1'b0, r);
        chk("stale_shadow", 64'(r), 64'd1);
        xfer(4'h0, 1'b0, 32'd0, 4'h0, 1'b0, r);
        xfer(4'h4, 1'b0, 32'd0, 4'h0, 1'b0, r);
        chk("fresh_shadow", 64'(r), 64'd7);

        // 64-bit wrap clears irq
        xfer(4'h4, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b0, r);
        xfer(4'h0, 1'b1, 32'hFFFF_FFFE, 4'hF, 1'b0, r);
        chk("irq_pre_wrap", 64'(irq), 64'd1);
        repeat (2) @(negedge clk);
        chk("irq_wrap_clear", 64'(irq), 64'd0);
        xfer(4'h0, 1'b0, 32'd0, 4'h0, 1'b0, r);
        chk("wrap_lo", 64'(r), 64'd1);
        xfer(4'h4, 1'b0, 32'd0, 4'h0, 1'b0, r);
        chk("wrap_hi", 64'(r), 64'd0);

        // byte-lane write
        xfer(4'h8, 1'b1, 32'hAABB_CCDD, 4'b0010, 1'b0, r);
        xfer(4'h8, 1'b0, 32'd0, 4'h0, 1'b0, r);
        chk("byte_lane", 64'(r), 64'hFFFF_CCFF);
        xfer(4'hC, 1'b0, 32'd0, 4'h0, 1'b0, r);
        chk("cmp_hi_read", 64'(r), 64'd0);

        // stb held through ack: one ack, one effect
        xfer(4'h0, 1'b1, 32'd5, 4'hF, 1'b1, r);
        xfer(4'h0, 1'b0, 32'd0, 4'h0, 1'b0, r);
        chk("hold_once_mtime", 64'(r), 64'd7);
        xfer(4'hC, 1'b1, 32'd5, 4'hF, 1'b1, r);
        xfer(4'hC, 1'b0, 32'd0, 4'h0, 1'b0, r);
        chk("hold_once_cmp", 64'(r), 64'd5);

        // reset while an access is in flight
        xfer(4'hC, 1'b1, 32'd0, 4'hF, 1'b0, r);
        xfer(4'h8, 1'b1, 32'd0, 4'hF, 1'b0, r);
        chk("irq_cmp0", 64'(irq), 64'd1);
        wb.adr = 32'h0; wb.we = 1'b0; wb.stb = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_ack_up", 64'(wb.ack), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ack", 64'(wb.ack), 64'd0);
        chk("mid_rst_rdt", 64'(wb.rdt), 64'd0);
        chk("mid_rst_irq", 64'(irq), 64'd0);
        wb.stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wb.adr = 32'h8; wb.we = 1'b1; wb.dat = 32'h1234; wb.sel = 4'hF; wb.stb = 1'b1;
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        wb.stb = 1'b0; wb.we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        xfer(4'h8, 1'b0, 32'd0, 4'h0, 1'b0, r);
        chk("rst_cmp_lo", 64'(r), 64'hFFFF_FFFF);
        xfer(4'hC, 1'b0, 32'd0, 4'h0, 1'b0, r);
        chk("rst_cmp_hi", 64'(r), 64'hFFFF_FFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
